// File: rtl/div_rr_scheduler.sv
// div_rr_scheduler: shares one multi-cycle divider core
// between NUM_REQ requesters with round-robin arbitration.
module div_rr_scheduler #(
    parameter int W       = 4,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_dividend,
    input  logic [NUM_REQ*W-1:0] req_divisor,
    output logic [NUM_REQ-1:0]   rsp_valid,
    input  logic [NUM_REQ-1:0]   rsp_ready,
    output logic [W-1:0]         rsp_quotient,
    output logic [W-1:0]         rsp_remainder,
    output logic                 rsp_dbz,
    output logic                 rsp_err,
    output logic                 core_start,
    output logic [W-1:0]         core_dividend,
    output logic [W-1:0]         core_divisor,
    input  logic                 core_done,
    input  logic [W-1:0]         core_quotient,
    input  logic [W-1:0]         core_remainder,
    output logic                 busy
);

    localparam int IW = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);
    localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

    logic [1:0]    state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] grant;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_inc;
    logic [IW-1:0] ptr_nxt;

    logic          found;
    logic [IW-1:0] pick;
    logic [IW-1:0] idx;
    logic [W-1:0]  sel_a;
    logic [W-1:0]  sel_b;

    assign sel_a    = req_dividend[int'(pick)*W +: W];
    assign sel_b    = req_divisor[int'(pick)*W +: W];
    assign tcnt_inc = tcnt + 1'b1;
    assign ptr_nxt  = (grant == LAST) ? '0 : grant + 1'b1;

    // First valid requester at or after ptr, wrapping around
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IW'((int'(ptr) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Accept strobe only while idle, held off during reset
    always_comb begin
        req_ready = '0;
        if (rst_n && state == S_IDLE && found) begin
            req_ready[pick] = 1'b1;
        end
    end

    // Sequencer: accept, issue, wait for core or timeout, respond
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            ptr           <= '0;
            grant         <= '0;
            tcnt          <= '0;
            core_start    <= 1'b0;
            core_dividend <= '0;
            core_divisor  <= '0;
            rsp_valid     <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_dbz       <= 1'b0;
            rsp_err       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            core_start <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (found) begin
                        grant         <= pick;
                        core_dividend <= sel_a;
                        core_divisor  <= sel_b;
                        busy          <= 1'b1;
                        if (sel_b == '0) begin
                            state         <= S_RESP;
                            rsp_valid     <= ONE << pick;
                            rsp_quotient  <= '1;
                            rsp_remainder <= sel_a;
                            rsp_dbz       <= 1'b1;
                            rsp_err       <= 1'b0;
                        end else begin
                            state      <= S_ISSUE;
                            core_start <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    tcnt  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        state         <= S_RESP;
                        rsp_valid     <= ONE << grant;
                        rsp_quotient  <= core_quotient;
                        rsp_remainder <= core_remainder;
                        rsp_dbz       <= 1'b0;
                        rsp_err       <= 1'b0;
                    end else if (tcnt_inc == TO_MAX) begin
                        state         <= S_RESP;
                        rsp_valid     <= ONE << grant;
                        rsp_quotient  <= '0;
                        rsp_remainder <= '0;
                        rsp_dbz       <= 1'b0;
                        rsp_err       <= 1'b1;
                    end else begin
                        tcnt <= tcnt_inc;
                    end
                end
                S_RESP: begin
                    if (rsp_ready[grant]) begin
                        state     <= S_IDLE;
                        rsp_valid <= '0;
                        ptr       <= ptr_nxt;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
